data_sram_responder: RTL and testbench



---
 rtl/data_sram_responder.sv | 118 +++++++++++
 tb/tb_data_sram_responder.sv | 268 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/data_sram_responder.sv
// Data SRAM responder: a single-ported word memory behind a split
// address/data handshake. Accepted requests enter a small in-order queue,
// each entry ages until it has waited LATENCY cycles, then retires with a
// one-cycle data_ok pulse. Stores write memory at acceptance; loads
// snapshot the addressed word at acceptance.
module data_sram_responder #(
  parameter int ADDR_W  = 10,
  parameter int DEPTH   = 2,
  parameter int LATENCY = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        data_sram_req,
  input  logic        data_sram_wr,
  input  logic [1:0]  data_sram_size,
  input  logic [31:0] data_sram_addr,
  input  logic [3:0]  data_sram_wstrb,
  input  logic [31:0] data_sram_wdata,
  output logic        data_sram_addr_ok,
  output logic        data_sram_data_ok,
  output logic [31:0] data_sram_rdata,
  input  logic        addr_stall
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int AGE_W = $clog2(LATENCY + 1);

  logic [31:0]      mem [2**ADDR_W];

  logic             q_wr    [DEPTH];
  logic [31:0]      q_rdata [DEPTH];
  logic [AGE_W-1:0] q_age   [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic             full;
  logic             accept;
  logic             retire;
  logic             head_ready;
  logic [ADDR_W-1:0] word_idx;

  // Byte-offset bits, address bits above the memory and the access size
  // do not affect behaviour; the memory simply aliases.
  logic             unused_bits;
  assign unused_bits = ^{data_sram_size, data_sram_addr[1:0],
                         data_sram_addr[31:ADDR_W+2]};

  function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
    return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // full looks only at registered occupancy, so a retirement in the same
  // cycle never opens the door for a new request.
  assign full              = (count == CNT_W'(DEPTH));
  assign data_sram_addr_ok = data_sram_req & ~full & ~addr_stall & ~reset;
  assign accept            = data_sram_req & data_sram_addr_ok;
  assign word_idx          = data_sram_addr[ADDR_W+1:2];

  assign head_ready        = (count != '0) && (q_age[rd_ptr] >= AGE_W'(LATENCY));
  assign data_sram_data_ok = head_ready & ~reset;
  assign retire            = data_sram_data_ok;
  assign data_sram_rdata   = (data_sram_data_ok && !q_wr[rd_ptr]) ? q_rdata[rd_ptr] : 32'h0;

  // Byte-lane store into memory at the accepting edge; memory is never reset.
  always_ff @(posedge clk) begin
    if (accept && data_sram_wr) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wstrb[i]) begin
          mem[word_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
        end
      end
    end
  end

  // Capture the response payload of an accepted request into the tail slot.
  always_ff @(posedge clk) begin
    if (accept) begin
      q_wr[wr_ptr]    <= data_sram_wr;
      q_rdata[wr_ptr] <= data_sram_wr ? 32'h0 : mem[word_idx];
    end
  end

  // Per-entry age: 1 the cycle after acceptance, saturating at LATENCY.
  always_ff @(posedge clk) begin
    for (int i = 0; i < DEPTH; i++) begin
      if (reset) begin
        q_age[i] <= '0;
      end else if (accept && (wr_ptr == PTR_W'(i))) begin
        q_age[i] <= AGE_W'(1);
      end else if (retire && (rd_ptr == PTR_W'(i))) begin
        q_age[i] <= '0;
      end else if ((q_age[i] != '0) && (q_age[i] != AGE_W'(LATENCY))) begin
        q_age[i] <= q_age[i] + 1'b1;
      end
    end
  end

  // Queue pointers and occupancy; reset drops everything outstanding.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (accept) wr_ptr <= ptr_inc(wr_ptr);
      if (retire) rd_ptr <= ptr_inc(rd_ptr);
      if (accept && !retire) begin
        count <= count + 1'b1;
      end else if (retire && !accept) begin
        count <= count - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_data_sram_responder.sv
// Testbench for data_sram_responder: directed requests push their expected
// responses into a scoreboard, and an independent monitor pops and checks
// each data_ok pulse for data, ordering and latency.
module tb_data_sram_responder;

  localparam int ADDR_W  = 10;
  localparam int DEPTH   = 2;
  localparam int LATENCY = 2;

  logic        clk;
  logic        reset;
  logic        data_sram_req;
  logic        data_sram_wr;
  logic [1:0]  data_sram_size;
  logic [31:0] data_sram_addr;
  logic [3:0]  data_sram_wstrb;
  logic [31:0] data_sram_wdata;
  logic        data_sram_addr_ok;
  logic        data_sram_data_ok;
  logic [31:0] data_sram_rdata;
  logic        addr_stall;

  typedef struct {
    logic [31:0] rdata;
    int          t;
    bit          exact;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   checks = 0;
  int   failures = 0;

  data_sram_responder #(
    .ADDR_W (ADDR_W),
    .DEPTH  (DEPTH),
    .LATENCY(LATENCY)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .data_sram_req    (data_sram_req),
    .data_sram_wr     (data_sram_wr),
    .data_sram_size   (data_sram_size),
    .data_sram_addr   (data_sram_addr),
    .data_sram_wstrb  (data_sram_wstrb),
    .data_sram_wdata  (data_sram_wdata),
    .data_sram_addr_ok(data_sram_addr_ok),
    .data_sram_data_ok(data_sram_data_ok),
    .data_sram_rdata  (data_sram_rdata),
    .addr_stall       (addr_stall)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Cycle counter: value seen at a negedge is the index of the current cycle.
  always @(posedge clk) cycle <= cycle + 1;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h (cycle %0d)", name, act, exp, cycle);
    end
  endtask

  task automatic pushExp(input logic [31:0] d, input int t);
    exp_t e;
    e.rdata = d;
    e.t     = t;
    e.exact = (sb.size() == 0);
    sb.push_back(e);
  endtask

  // Present one request and hold it until accepted; called just after a posedge.
  task automatic applyStimulus(input logic wr, input logic [31:0] addr, input logic [3:0] wstrb,
                               input logic [31:0] wdata, input logic [31:0] exp);
    bit accepted = 0;
    int waited = 0;
    data_sram_req   = 1'b1;
    data_sram_wr    = wr;
    data_sram_size  = 2'd2;
    data_sram_addr  = addr;
    data_sram_wstrb = wstrb;
    data_sram_wdata = wdata;
    while (!accepted && waited < 20) begin
      @(negedge clk);
      if (data_sram_addr_ok === 1'b1) begin
        accepted = 1;
        pushExp(exp, cycle);
      end
      waited++;
      @(posedge clk);
      #1;
    end
    data_sram_req = 1'b0;
    if (!accepted) begin
      checks++;
      failures++;
      $display("[TB] FAIL accept_timeout: addr 0x%08h never accepted, required addr_ok=1", addr);
    end
  endtask

  task automatic waitDrain();
    int n = 0;
    while (sb.size() != 0 && n < 50) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      failures++;
      $display("[TB] FAIL drain_timeout: %0d responses outstanding, required 0", sb.size());
    end
  endtask

  // Monitor: every data_ok pulse must match the oldest expectation, no
  // earlier than LATENCY cycles after acceptance (exactly LATENCY when it
  // had no queue ahead of it); rdata must be zero when idle.
  always @(negedge clk) begin
    exp_t e;
    int   lat;
    if (data_sram_data_ok === 1'b1) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("[TB] FAIL unexpected_data_ok: got data_ok=1 expected 0 (cycle %0d)", cycle);
      end else begin
        e   = sb.pop_front();
        lat = cycle - e.t;
        checkOutput("rdata", data_sram_rdata, e.rdata);
        if (e.exact) begin
          checkOutput("latency_exact", 32'(lat), 32'(LATENCY));
        end else begin
          checks++;
          if (lat < LATENCY) begin
            failures++;
            $display("[TB] FAIL latency_min: got %0d expected >= %0d", lat, LATENCY);
          end
        end
      end
    end else if (!reset) begin
      checkOutput("idle_rdata", data_sram_rdata, 32'h0);
    end
  end

  initial begin
    bit ao [7];
    bit dk [7];
    int acc;
    bit ao_exp [7] = '{1, 1, 0, 1, 0, 0, 0};
    bit dk_exp [7] = '{0, 0, 1, 1, 0, 1, 0};

    reset           = 1'b1;
    addr_stall      = 1'b0;
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b0;
    data_sram_size  = 2'd2;
    data_sram_addr  = 32'h0;
    data_sram_wstrb = 4'h0;
    data_sram_wdata = 32'h0;

    // Reset cycle: request held but must not be accepted.
    @(negedge clk);
    checkOutput("reset_addr_ok", 32'(data_sram_addr_ok), 32'h0);
    checkOutput("reset_data_ok", 32'(data_sram_data_ok), 32'h0);
    @(posedge clk); #1;
    reset = 1'b0;
    data_sram_req = 1'b0;
    @(negedge clk);
    checkOutput("post_reset_data_ok", 32'(data_sram_data_ok), 32'h0);
    @(posedge clk); #1;

    // Word store then load of the same word.
    applyStimulus(1'b1, 32'h100, 4'hF, 32'h11223344, 32'h0);
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 32'h11223344);
    waitDrain();

    // Single byte lane store, load through an unaligned byte address.
    applyStimulus(1'b1, 32'h100, 4'b0100, 32'hAAAAAAAA, 32'h0);
    applyStimulus(1'b0, 32'h103, 4'h0, 32'h0, 32'h11AA3344);
    waitDrain();

    // Three loads with req held: queue fills and back-pressures.
    acc = 0;
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h100;
    for (int c = 0; c < 7; c++) begin
      @(negedge clk);
      ao[c] = data_sram_addr_ok;
      dk[c] = data_sram_data_ok;
      if (data_sram_addr_ok === 1'b1) begin
        pushExp(32'h11AA3344, cycle);
        acc++;
      end
      @(posedge clk); #1;
      if (acc == 3) data_sram_req = 1'b0;
    end
    for (int c = 0; c < 7; c++) begin
      checkOutput($sformatf("fill_addr_ok_c%0d", c), 32'(ao[c]), 32'(ao_exp[c]));
      checkOutput($sformatf("fill_data_ok_c%0d", c), 32'(dk[c]), 32'(dk_exp[c]));
    end
    waitDrain();

    // Stalled store must have no effect on memory.
    applyStimulus(1'b1, 32'h300, 4'hF, 32'h01020304, 32'h0);
    addr_stall      = 1'b1;
    data_sram_req   = 1'b1;
    data_sram_wr    = 1'b1;
    data_sram_addr  = 32'h300;
    data_sram_wstrb = 4'hF;
    data_sram_wdata = 32'hFFFFFFFF;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      checkOutput("stall_addr_ok", 32'(data_sram_addr_ok), 32'h0);
      @(posedge clk); #1;
    end
    data_sram_req = 1'b0;
    addr_stall    = 1'b0;
    applyStimulus(1'b0, 32'h300, 4'h0, 32'h0, 32'h01020304);
    waitDrain();

    // Stall release: accepted in the first cycle without the stall.
    addr_stall     = 1'b1;
    data_sram_req  = 1'b1;
    data_sram_wr   = 1'b0;
    data_sram_addr = 32'h100;
    @(negedge clk);
    checkOutput("stall_load_addr_ok", 32'(data_sram_addr_ok), 32'h0);
    @(posedge clk); #1;
    addr_stall = 1'b0;
    @(negedge clk);
    checkOutput("release_addr_ok", 32'(data_sram_addr_ok), 32'h1);
    if (data_sram_addr_ok === 1'b1) pushExp(32'h11AA3344, cycle);
    @(posedge clk); #1;
    data_sram_req = 1'b0;
    waitDrain();

    // Reset while two loads are outstanding: both responses are dropped.
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 32'h11AA3344);
    applyStimulus(1'b0, 32'h300, 4'h0, 32'h0, 32'h01020304);
    reset = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    reset = 1'b0;
    @(negedge clk);
    checkOutput("count_after_reset", 32'(dut.count), 32'h0);
    repeat (5) @(posedge clk);
    #1;
    applyStimulus(1'b0, 32'h100, 4'h0, 32'h0, 32'h11AA3344);
    waitDrain();

    // Address aliasing above the memory size.
    applyStimulus(1'b1, 32'h1000, 4'hF, 32'hDEADBEEF, 32'h0);
    applyStimulus(1'b0, 32'h0000, 4'h0, 32'h0, 32'hDEADBEEF);
    waitDrain();

    repeat (3) @(posedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
